// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DataBits data bits (LSB first), optional parity, 1-2 stop bits.
// Optional feature: parity generation is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_cfg #(
  parameter int TicksPerBaud = 104,
  parameter int DataBits     = 8,
  parameter int Parity       = 0,
  parameter int StopBits     = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DataBits-1:0] tx_data_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  output logic                tx_busy_o,
  output logic                uart_tx_o
);

  localparam int CntW = (TicksPerBaud > 1) ? $clog2(TicksPerBaud) : 1;
  localparam int IdxW = $clog2(DataBits);
  localparam logic [CntW-1:0] CntLast = CntW'(TicksPerBaud - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DataBits - 1);
  localparam logic            StopLast = 1'(StopBits - 1);

  if (TicksPerBaud < 2 || DataBits < 5 || DataBits > 9 ||
      StopBits < 1 || StopBits > 2 || Parity < 0 || Parity > 2) begin : g_param_check
    $error("uart_tx_cfg: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_e;

  state_e              state_r, state_s;
  logic [CntW-1:0]     cnt_r, cnt_s;
  logic [IdxW-1:0]     idx_r, idx_s;
  logic                stop_r, stop_s;
  logic [DataBits-1:0] shift_r, shift_s;
  logic                tx_r, tx_s;
  logic                ready_r, ready_s;
  logic                busy_r, busy_s;
  logic                bit_end_s;

`ifdef UART_TX_PARITY_EN
  localparam bit ParOn = (Parity != 0);
  localparam bit ParOdd = (Parity == 2);

  logic par_r, par_s;

  function automatic logic parity_bit(input logic [DataBits-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction
`endif

  // Next-state, counters and next line level; the line is registered from these values.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    stop_s    = stop_r;
    shift_s   = shift_r;
    tx_s      = tx_r;
    ready_s   = ready_r;
`ifdef UART_TX_PARITY_EN
    par_s     = par_r;
`endif
    bit_end_s = (cnt_r == CntLast);

    case (state_r)
      IDLE: begin
        cnt_s  = {CntW{1'b0}};
        idx_s  = {IdxW{1'b0}};
        stop_s = 1'b0;
        if (ready_r && tx_valid_i) begin
          state_s = START;
          shift_s = tx_data_i;
          ready_s = 1'b0;
          tx_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_s   = parity_bit(tx_data_i, ParOdd);
`endif
        end else begin
          ready_s = 1'b1;
          tx_s    = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          cnt_s   = {CntW{1'b0}};
          tx_s    = shift_r[0];
        end else begin
          cnt_s   = cnt_r + CntW'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_s = {CntW{1'b0}};
          if (idx_r == IdxLast) begin
`ifdef UART_TX_PARITY_EN
            if (ParOn) begin
              state_s = PAR;
              tx_s    = par_r;
            end else begin
              state_s = STOP;
              tx_s    = 1'b1;
            end
`else
            state_s = STOP;
            tx_s    = 1'b1;
`endif
          end else begin
            // The next bit is the current register's bit 1, i.e. the LSB after the shift.
            idx_s   = idx_r + IdxW'(1);
            shift_s = {1'b0, shift_r[DataBits-1:1]};
            tx_s    = shift_r[1];
          end
        end else begin
          cnt_s = cnt_r + CntW'(1);
        end
      end
      PAR: begin
        if (bit_end_s) begin
          state_s = STOP;
          cnt_s   = {CntW{1'b0}};
          tx_s    = 1'b1;
        end else begin
          cnt_s   = cnt_r + CntW'(1);
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_s = {CntW{1'b0}};
          if (stop_r == StopLast) begin
            state_s = IDLE;
            ready_s = 1'b1;
            tx_s    = 1'b1;
          end else begin
            stop_s  = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CntW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CntW{1'b0}};
        tx_s    = 1'b1;
        ready_s = 1'b0;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      cnt_r   <= {CntW{1'b0}};
      idx_r   <= {IdxW{1'b0}};
      stop_r  <= 1'b0;
      shift_r <= {DataBits{1'b0}};
      tx_r    <= 1'b1;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      stop_r  <= stop_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
`ifdef UART_TX_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

  assign uart_tx_o  = tx_r;
  assign tx_ready_o = ready_r;
  assign tx_busy_o  = busy_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg at T = 4: reset, 8N1 frames, back-to-back, mid-frame reset,
// and 7-bit/2-stop and 8-bit parity variants whose expected frames depend on UART_TX_PARITY_EN.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic [3:0] valid = 4'b0000;
  logic [3:0] tx;
  logic [3:0] rdy;
  logic [3:0] busy;

  int checks = 0;
  int failures = 0;

  // Frame bit i (time order) is stored in bit i of each constant.
`ifdef UART_TX_PARITY_EN
  localparam logic [15:0] Exp7Even = 16'b0000_0110_1010_1010;
  localparam logic [15:0] Exp7Odd  = 16'b0000_0111_1010_1010;
  localparam int          Len7     = 11;
  localparam logic [15:0] Exp8Par  = 16'b0000_0110_0000_0010;
  localparam int          Len8Par  = 11;
`else
  localparam logic [15:0] Exp7Even = 16'b0000_0011_1010_1010;
  localparam logic [15:0] Exp7Odd  = 16'b0000_0011_1010_1010;
  localparam int          Len7     = 10;
  localparam logic [15:0] Exp8Par  = 16'b0000_0010_0000_0010;
  localparam int          Len8Par  = 10;
`endif

  always #5 clk = ~clk;

  uart_tx_cfg #(.TicksPerBaud(4), .DataBits(8), .Parity(0), .StopBits(1)) dut_8n1 (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(data), .tx_valid_i(valid[0]),
    .tx_ready_o(rdy[0]), .tx_busy_o(busy[0]), .uart_tx_o(tx[0]));

  uart_tx_cfg #(.TicksPerBaud(4), .DataBits(7), .Parity(1), .StopBits(2)) dut_7e2 (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(data[6:0]), .tx_valid_i(valid[1]),
    .tx_ready_o(rdy[1]), .tx_busy_o(busy[1]), .uart_tx_o(tx[1]));

  uart_tx_cfg #(.TicksPerBaud(4), .DataBits(7), .Parity(2), .StopBits(2)) dut_7o2 (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(data[6:0]), .tx_valid_i(valid[2]),
    .tx_ready_o(rdy[2]), .tx_busy_o(busy[2]), .uart_tx_o(tx[2]));

  uart_tx_cfg #(.TicksPerBaud(4), .DataBits(8), .Parity(1), .StopBits(1)) dut_8p1 (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(data), .tx_valid_i(valid[3]),
    .tx_ready_o(rdy[3]), .tx_busy_o(busy[3]), .uart_tx_o(tx[3]));

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Waits (bounded) for ready, presents word, and returns #1 after the accepting edge.
  task automatic send(input int idx, input logic [7:0] word, input logic [7:0] after, input logic keep);
    int n = 0;
    while (rdy[idx] !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_wait", rdy[idx], 1'b1);
    data = word;
    valid[idx] = 1'b1;
    @(posedge clk);
    #1;
    data = after;
    valid[idx] = keep;
    check("accept_ready_low", rdy[idx], 1'b0);
  endtask

  // Checks every cycle of a frame starting at cycle A+1, then the return to idle.
  task automatic check_frame(input int idx, input logic [15:0] bits, input int nbits, input string tag);
    for (int c = 0; c < nbits * 4; c++) begin
      if (c != 0) begin
        @(posedge clk);
        #1;
      end
      check({tag, "_line"}, tx[idx], bits[c / 4]);
      check({tag, "_busy"}, busy[idx], 1'b1);
      check({tag, "_rdy_low"}, rdy[idx], 1'b0);
    end
    @(posedge clk);
    #1;
    check({tag, "_end_rdy"}, rdy[idx], 1'b1);
    check({tag, "_end_busy"}, busy[idx], 1'b0);
    check({tag, "_end_line"}, tx[idx], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_line", tx[0], 1'b1);
      check("rst_rdy", rdy[0], 1'b0);
      check("rst_busy", busy[0], 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_rdy", rdy[0], 1'b1);
    check("release_busy", busy[0], 1'b0);
    check("release_line", tx[0], 1'b1);

    // 0xA5: 0,1,0,1,0,0,1,0,1,1; data is changed right after acceptance
    send(0, 8'hA5, 8'h5A, 1'b0);
    check_frame(0, 16'b0000_0011_0100_1010, 10, "a5");

    // Back-to-back 0x00 then 0xFF with valid held high
    send(0, 8'h00, 8'hFF, 1'b1);
    check_frame(0, 16'b0000_0010_0000_0000, 10, "b2b_first");
    @(posedge clk);
    #1;
    check("b2b_second_accept", rdy[0], 1'b0);
    data = 8'h00;
    valid[0] = 1'b0;
    check_frame(0, 16'b0000_0011_1111_1110, 10, "b2b_second");

    // Mid-frame reset: asserted during cycle A+10 of a 0x00 frame
    send(0, 8'h00, 8'hFF, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_line", tx[0], 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_line", tx[0], 1'b1);
    check("midrst_rdy", rdy[0], 1'b0);
    check("midrst_busy", busy[0], 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_release_rdy", rdy[0], 1'b1);
    send(0, 8'h3C, 8'hC3, 1'b0);
    check_frame(0, 16'b0000_0010_0111_1000, 10, "x3c");

    // 7-bit, 2 stop bits, 0x55 with even and odd parity settings
    send(1, 8'h55, 8'h2A, 1'b0);
    check_frame(1, Exp7Even, Len7, "p7even");
    send(2, 8'h55, 8'h2A, 1'b0);
    check_frame(2, Exp7Odd, Len7, "p7odd");

    // 8 data bits, Parity = 1, send 0x01
    send(3, 8'h01, 8'hFE, 1'b0);
    check_frame(3, Exp8Par, Len8Par, "p8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It serialises one word per accepted transfer onto an idle-high TX line. Character width, parity and stop-bit count are set at elaboration time, and the input has a valid/ready handshake with backpressure. It sits between a Wishbone-side TX register or FIFO and the board pin.

## Interface
Parameters:
- TicksPerBaud, default 104: clock cycles per bit; legal range >= 2.
- DataBits, default 8: data bits per character; legal range 5..9.
- Parity, default 0: 0 = none, 1 = even, 2 = odd; only honoured under UART_TX_PARITY_EN.
- StopBits, default 1: number of stop bits; 1 or 2.

Ports:
- clk_i, in, 1: single clock.
- rst_ni, in, 1: reset; synchronous, active-low.
- tx_data_i, in, DataBits: word to send; LSB is sent first.
- tx_valid_i, in, 1: tx_data_i is valid.
- tx_ready_o, out, 1: block can accept a word; a transfer occurs when valid and ready are both high on a rising edge.
- tx_busy_o, out, 1: a frame is in progress (state is not Idle).
- uart_tx_o, out, 1: serial line; idle and stop level is 1.

## Operation
- States: Idle, Start, Data, Par, Stop.
- Idle -> Start on a transfer. tx_data_i is latched into a DataBits shift register at that edge. The parity bit is computed from the latched word at that edge: even = XOR of all bits; odd = inverted XOR.
- Start -> Data after one bit time.
- Data:
  - Each bit time, the next bit is shifted out, LSB first.
  - A bit index counts 0..DataBits-1.
  - After the last data bit: go to Par if parity is enabled, otherwise go to Stop.
- Par -> Stop after one bit time.
- Stop:
  - Lasts StopBits bit times.
  - Then go to Idle with tx_ready_o set in the same edge.
- Baud counter:
  - Width is $clog2(TicksPerBaud).
  - Counts 0..TicksPerBaud-1, then wraps to 0 and advances the bit.
  - Held at 0 in Idle.
- uart_tx_o is a registered output, driven from the state and the shift-register LSB. It has no combinational path from any input.
- tx_ready_o is registered:
  - Cleared on the accepting edge.
  - Low for the whole frame.
  - tx_valid_i and tx_data_i are don't-care while tx_ready_o is low.
- Data changes after acceptance do not affect the frame in flight.
- Frame length N = 1 + DataBits + P + StopBits bits, where P = 1 if parity is active, else 0.
- Illegal parameter values are rejected by an elaboration-time check ($error). These are: TicksPerBaud < 2, DataBits outside 5..9, StopBits outside 1..2, or Parity > 2.

## Timing
- Reset values: uart_tx_o = 1, tx_ready_o = 0, tx_busy_o = 0, state = Idle, counters = 0.
- tx_ready_o rises on the first edge with rst_ni high.
- Reset asserted mid-frame: on the next edge the line returns to 1 and the frame is abandoned. The receiver then sees a truncated frame, which is acceptable.
- Acceptance at edge A:
  - uart_tx_o = 0 (start bit) from cycle A+1 through A+T, where T = TicksPerBaud.
  - Data bit k is driven for cycles A+1+(k+1)T through A+(k+2)T.
- Last stop cycle is A+N*T. At edge A+N*T, state = Idle and tx_ready_o = 1.
- Back-to-back: with tx_valid_i held high, the next acceptance happens at A+N*T+1. Start-to-start spacing is therefore exactly N*T+1 cycles, and the stop level is extended by one cycle.
- tx_busy_o is high from A+1 through A+N*T inclusive.
- If valid and reset are active in the same cycle, reset wins and no transfer occurs.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined: the Parity parameter is honoured, the Par state and the parity register exist, and P = 1 when Parity != 0.
- Undefined: no parity logic is synthesised, the Parity parameter is ignored, P = 0 always, and Data goes directly to Stop.

## Test plan
- Reset then idle: hold rst_ni low for 3 cycles, then release. Required: uart_tx_o = 1 throughout, tx_ready_o = 0 during reset, tx_ready_o = 1 on the first edge after release, tx_busy_o = 0.
- 8N1, T = 4, send 0xA5: line reads 0,1,0,1,0,0,1,0,1,1, each bit held for 4 cycles. Start bit begins 1 cycle after acceptance. tx_ready_o returns high after 40 cycles.
- 7E2, T = 4, UART_TX_PARITY_EN defined, send 0x55: line reads start 0, data 1,0,1,0,1,0,1, parity 0, stop 1,1. Frame is 44 cycles. With Parity = 2 (odd), the parity bit is 1.
- Back-to-back 8N1, T = 4, tx_valid_i held high, send 0x00 then 0xFF: the second start edge is exactly 41 cycles after the first. tx_data_i changes mid-frame do not alter the first frame.
- Mid-frame reset, 8N1, T = 4: pull rst_ni low 10 cycles into a frame of 0x00. Required: uart_tx_o = 1 on the next edge, tx_ready_o = 0, and after release a clean frame of 0x3C is sent correctly.
- Parity compiled out: UART_TX_PARITY_EN undefined, Parity = 1, send 0x01 at 8 data bits. Required: 10-bit frame, no parity bit, 40 cycles at T = 4.
